// File: rtl/popcount_window_acc.sv
// rtl/popcount_window_acc.sv - windowed sum/max/min accumulator for popcount samples
// Collects WIN samples, then holds the result on a valid/ready output while stalling input.
module popcount_window_acc #(
  parameter int IN_W  = 4,
  parameter int WIN   = 8,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [IN_W-1:0]  out_max,
  output logic [IN_W-1:0]  out_min,
  output logic             out_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  // One spare bit above the wider operand so the raw sum can never wrap.
  localparam int EXT_W = ((SUM_W > IN_W) ? SUM_W : IN_W) + 1;
  localparam logic [EXT_W-1:0] SUM_MAX = EXT_W'((64'd1 << SUM_W) - 64'd1);
  localparam logic [7:0] LAST_CNT = 8'(WIN - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [SUM_W-1:0] acc_sum;
  logic [IN_W-1:0]  acc_max;
  logic [IN_W-1:0]  acc_min;
  logic             acc_sat;

  logic [EXT_W-1:0] sum_ext;
  logic             add_sat;
  logic [SUM_W-1:0] nxt_sum;
  logic [IN_W-1:0]  nxt_max;
  logic [IN_W-1:0]  nxt_min;
  logic             nxt_sat;
  logic             last;

  assign in_ready = (state == ACCUM);
  assign last     = (cnt == LAST_CNT);

  always_comb begin
    sum_ext = EXT_W'(acc_sum) + EXT_W'(in_data);
    add_sat = (sum_ext > SUM_MAX);
    nxt_sum = add_sat ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    nxt_sat = acc_sat | add_sat;
    nxt_max = (in_data > acc_max) ? in_data : acc_max;
    nxt_min = (in_data < acc_min) ? in_data : acc_min;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= 8'd0;
      acc_sum   <= '0;
      acc_max   <= '0;
      acc_min   <= '1;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      out_min   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clr) begin
            cnt     <= 8'd0;
            acc_sum <= '0;
            acc_max <= '0;
            acc_min <= '1;
            acc_sat <= 1'b0;
          end else if (in_valid) begin
            if (last) begin
              out_sum   <= nxt_sum;
              out_max   <= nxt_max;
              out_min   <= nxt_min;
              out_sat   <= nxt_sat;
              out_valid <= 1'b1;
              cnt       <= 8'd0;
              acc_sum   <= '0;
              acc_max   <= '0;
              acc_min   <= '1;
              acc_sat   <= 1'b0;
              state     <= HOLD;
            end else begin
              acc_sum <= nxt_sum;
              acc_max <= nxt_max;
              acc_min <= nxt_min;
              acc_sat <= nxt_sat;
              cnt     <= cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          // clr is deliberately ignored here so a pending result is never lost.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_window_acc.sv
// tb/tb_popcount_window_acc.sv - directed self-checking bench for popcount_window_acc
// Three instances (default, SUM_W=5, WIN=1) share stimulus; each phase resets and checks one.
module tb_popcount_window_acc;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_sat0;
  logic [7:0] out_sum0;
  logic [3:0] out_max0, out_min0;

  logic       in_ready1, out_valid1, out_sat1;
  logic [4:0] out_sum1;
  logic [3:0] out_max1, out_min1;

  logic       in_ready2, out_valid2, out_sat2;
  logic [7:0] out_sum2;
  logic [3:0] out_max2, out_min2;

  int errors = 0;
  int checks = 0;

  popcount_window_acc #(.IN_W(4), .WIN(8), .SUM_W(8)) u_def (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_max(out_max0), .out_min(out_min0), .out_sat(out_sat0)
  );

  popcount_window_acc #(.IN_W(4), .WIN(8), .SUM_W(5)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_max(out_max1), .out_min(out_min1), .out_sat(out_sat1)
  );

  popcount_window_acc #(.IN_W(4), .WIN(1), .SUM_W(8)) u_one (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_max(out_max2), .out_min(out_min2), .out_sat(out_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
  endtask

  // Reset pulse placed between edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic chk_def(input string tag, input logic [7:0] s, input logic [3:0] mx,
                         input logic [3:0] mn, input logic st);
    chk({tag, "_sum"}, 32'(out_sum0), 32'(s));
    chk({tag, "_max"}, 32'(out_max0), 32'(mx));
    chk({tag, "_min"}, 32'(out_min0), 32'(mn));
    chk({tag, "_sat"}, 32'(out_sat0), 32'(st));
  endtask

  logic [3:0] vec [8];

  initial begin
    vec[0] = 4'd3; vec[1] = 4'd0; vec[2] = 4'd8; vec[3] = 4'd1;
    vec[4] = 4'd4; vec[5] = 4'd4; vec[6] = 4'd2; vec[7] = 4'd5;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    #12 rst = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk_def("rst", 8'd0, 4'd0, 4'd0, 1'b0);

    // Basic window, out_ready high
    for (int i = 0; i < 7; i++) feed(vec[i]);
    chk("t1_valid_early", 32'(out_valid0), 32'd0);
    feed(vec[7]);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid0), 32'd1);
    chk("t1_in_ready_low", 32'(in_ready0), 32'd0);
    chk_def("t1", 8'd27, 4'd8, 4'd0, 1'b0);
    step();
    chk("t1_valid_drop", 32'(out_valid0), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready0), 32'd1);
    chk("t1_sum_kept", 32'(out_sum0), 32'd27);

    // Backpressure with a 9th sample held on the input
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) feed(vec[i]);
    in_valid = 1'b1;
    in_data  = 4'd7;
    chk("t2_valid", 32'(out_valid0), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t2_hold_valid", 32'(out_valid0), 32'd1);
      chk("t2_hold_in_ready", 32'(in_ready0), 32'd0);
      chk("t2_hold_sum", 32'(out_sum0), 32'd27);
      chk("t2_hold_min", 32'(out_min0), 32'd0);
    end
    // clr during HOLD must not drop the pending result
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr_hold_valid", 32'(out_valid0), 32'd1);
    out_ready = 1'b1;
    step();
    chk("t2_release_valid", 32'(out_valid0), 32'd0);
    chk("t2_release_in_ready", 32'(in_ready0), 32'd1);
    feed(4'd7);
    for (int i = 0; i < 6; i++) feed(4'd0);
    chk("t2_next_early", 32'(out_valid0), 32'd0);
    feed(4'd0);
    in_valid = 1'b0;
    chk("t2_next_valid", 32'(out_valid0), 32'd1);
    chk_def("t2_next", 8'd7, 4'd7, 4'd0, 1'b0);
    step();

    // clr flushes a partial window, same-cycle sample dropped
    for (int i = 0; i < 5; i++) feed(4'd6);
    clr = 1'b1;
    feed(4'd2);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) feed(4'd1);
    in_valid = 1'b0;
    chk("t4_valid", 32'(out_valid0), 32'd1);
    chk_def("t4", 8'd8, 4'd1, 4'd1, 1'b0);
    step();

    // Async reset mid-window
    for (int i = 0; i < 4; i++) feed(4'd9);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5a_in_ready", 32'(in_ready0), 32'd1);
    chk_def("t5a", 8'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) feed(4'(i + 1) & 4'd7);
    in_valid = 1'b0;
    chk("t5a_valid", 32'(out_valid0), 32'd1);
    chk_def("t5a_win", 8'd28, 4'd7, 4'd0, 1'b0);

    // Async reset during HOLD
    out_ready = 1'b0;
    step();
    chk("t5b_holding", 32'(out_valid0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5b_valid", 32'(out_valid0), 32'd0);
    chk("t5b_in_ready", 32'(in_ready0), 32'd1);
    chk_def("t5b", 8'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) feed(4'd2);
    in_valid = 1'b0;
    chk("t5b_valid_win", 32'(out_valid0), 32'd1);
    chk_def("t5b_win", 8'd16, 4'd2, 4'd2, 1'b0);
    step();

    // Saturation instance, SUM_W=5
    pulse_reset();
    step();
    for (int i = 0; i < 8; i++) feed(4'd8);
    in_valid = 1'b0;
    chk("t3_valid", 32'(out_valid1), 32'd1);
    chk("t3_sum", 32'(out_sum1), 32'd31);
    chk("t3_sat", 32'(out_sat1), 32'd1);
    chk("t3_max", 32'(out_max1), 32'd8);
    chk("t3_min", 32'(out_min1), 32'd8);
    step();

    // WIN=1 instance
    pulse_reset();
    step();
    in_valid = 1'b1;
    in_data  = 4'd5;
    chk("t6_in_ready0", 32'(in_ready2), 32'd1);
    step();
    chk("t6_valid_a", 32'(out_valid2), 32'd1);
    chk("t6_in_ready1", 32'(in_ready2), 32'd0);
    chk("t6_sum_a", 32'(out_sum2), 32'd5);
    chk("t6_max_a", 32'(out_max2), 32'd5);
    chk("t6_min_a", 32'(out_min2), 32'd5);
    in_data = 4'd0;
    step();
    chk("t6_valid_gap", 32'(out_valid2), 32'd0);
    chk("t6_in_ready2", 32'(in_ready2), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t6_valid_b", 32'(out_valid2), 32'd1);
    chk("t6_sum_b", 32'(out_sum2), 32'd0);
    chk("t6_max_b", 32'(out_max2), 32'd0);
    chk("t6_min_b", 32'(out_min2), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
